// File: rtl/image_ram_reader_pkg.sv
// Shared types and constants for the ping-pong pixel RAM drain path.
package image_ram_reader_pkg;

  // Reader sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int WORDS_PER_BANK = 256;
  localparam int PACK_WORDS     = 4;
  localparam int FIFO_W         = 64;
  localparam int PIX_W          = 16;
  localparam int ADDR_W         = 8;
  localparam int LANE_W         = $clog2(PACK_WORDS);

  // True when the address is the final word of a bank.
  function automatic logic is_last_addr(input logic [ADDR_W-1:0] a);
    return a == ADDR_W'(WORDS_PER_BANK - 1);
  endfunction

endpackage

// File: rtl/image_word_packer.sv
// Packs a stream of 16-bit pixels into 64-bit words, first pixel in the low lane.
// The async reset clears the output register immediately on frame; the
// synchronous clear is kept so the packer can also be flushed without a reset.
module image_word_packer
  import image_ram_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  output logic [FIFO_W-1:0] word,
  output logic              word_valid
);

  // Lane index of the next pixel and the lanes collected so far.
  logic [LANE_W-1:0]       lane_reg;
  logic [FIFO_W-PIX_W-1:0] partial_reg;

  // Collect pixels into lanes; emit the full word when the top lane arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_reg    <= '0;
      partial_reg <= '0;
      word        <= '0;
      word_valid  <= 1'b0;
    end else if (clr) begin
      lane_reg    <= '0;
      partial_reg <= '0;
      word        <= '0;
      word_valid  <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (pix_valid) begin
        if (lane_reg == LANE_W'(PACK_WORDS - 1)) begin
          word       <= {pix_data, partial_reg};
          word_valid <= 1'b1;
        end else begin
          partial_reg[lane_reg*PIX_W +: PIX_W] <= pix_data;
        end
        lane_reg <= lane_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/image_ram_reader.sv
// Drains the two ping-pong pixel RAMs bank by bank in address order and
// hands 64-bit packed words to the DDR3 write FIFO.
// RD_LATENCY may be 1 or 2; GUARD_CYC should be at least 1.
module image_ram_reader
  import image_ram_reader_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int GUARD_CYC  = 4
) (
  input  logic              clk_cmos,
  input  logic              frame,
  input  logic              image_select_pulse,
  input  logic [PIX_W-1:0]  ram_dout1,
  input  logic [PIX_W-1:0]  ram_dout2,
  input  logic              fifo_almost_full,
  output logic [ADDR_W-1:0] ram_rd_addr,
  output logic              ram_rd_en1,
  output logic              ram_rd_en2,
  output logic [FIFO_W-1:0] fifo_din,
  output logic              fifo_wr_en,
  output logic              buf_done,
  output logic              overrun,
  output logic              busy
);

  // One counter serves both the guard wait and the drain wait.
  localparam int CW         = $clog2(GUARD_CYC + RD_LATENCY + 1);
  localparam int GUARD_LOAD = (GUARD_CYC > 0) ? GUARD_CYC - 1 : 0;

  state_t              state_reg, state_next;
  logic [CW-1:0]       cnt_reg, cnt_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [1:0]          rdy_reg, rdy_next;
  logic                wr_bank_reg;
  logic                rd_bank_reg;
  logic                overrun_reg;
  logic                buf_done_reg;
  logic                issue;
  logic                drain_done;
  logic [RD_LATENCY-1:0] pipe_v_reg;
  logic [RD_LATENCY-1:0] pipe_b_reg;
  logic [PIX_W-1:0]    ret_data;

  // Sequencer state, counter and read address registers.
  always_ff @(posedge clk_cmos or posedge frame) begin
    if (frame) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
    end
  end

  // Next-state logic: wait for a full bank, guard, stream 256 reads, drain.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    issue      = 1'b0;
    drain_done = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (rdy_reg[rd_bank_reg]) begin
          state_next = ST_GUARD;
          cnt_next   = CW'(GUARD_LOAD);
        end
      end
      ST_GUARD: begin
        if (cnt_reg == '0) begin
          state_next = ST_READ;
          addr_next  = '0;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_READ: begin
        // Backpressure only holds off new reads; in-flight ones still land.
        if (!fifo_almost_full) begin
          issue = 1'b1;
          if (is_last_addr(addr_reg)) begin
            state_next = ST_DRAIN;
            addr_next  = '0;
            cnt_next   = CW'(RD_LATENCY);
          end else begin
            addr_next = addr_reg + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        // Let the last read return and the final packed word get written.
        if (cnt_reg == '0) begin
          drain_done = 1'b1;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Ready flags: drain completion clears, writer pulse sets; the set wins.
  always_comb begin
    rdy_next = rdy_reg;
    if (drain_done) begin
      rdy_next[rd_bank_reg] = 1'b0;
    end
    if (image_select_pulse) begin
      rdy_next[wr_bank_reg] = 1'b1;
    end
  end

  // Bank ownership, sticky overrun and the bank-complete pulse.
  always_ff @(posedge clk_cmos or posedge frame) begin
    if (frame) begin
      rdy_reg      <= '0;
      wr_bank_reg  <= 1'b0;
      rd_bank_reg  <= 1'b0;
      overrun_reg  <= 1'b0;
      buf_done_reg <= 1'b0;
    end else begin
      rdy_reg      <= rdy_next;
      buf_done_reg <= drain_done;
      if (image_select_pulse) begin
        wr_bank_reg <= ~wr_bank_reg;
        if (rdy_reg[wr_bank_reg]) begin
          overrun_reg <= 1'b1;
        end
      end
      if (drain_done) begin
        rd_bank_reg <= ~rd_bank_reg;
      end
    end
  end

  // Delay line marking which cycles carry returning RAM data and from which bank.
  always_ff @(posedge clk_cmos or posedge frame) begin
    if (frame) begin
      pipe_v_reg <= '0;
      pipe_b_reg <= '0;
    end else begin
      pipe_v_reg[0] <= issue;
      pipe_b_reg[0] <= rd_bank_reg;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_v_reg[i] <= pipe_v_reg[i-1];
        pipe_b_reg[i] <= pipe_b_reg[i-1];
      end
    end
  end

  assign ret_data = pipe_b_reg[RD_LATENCY-1] ? ram_dout2 : ram_dout1;

  image_word_packer u_packer (
    .clk        (clk_cmos),
    .rst        (frame),
    .clr        (frame),
    .pix_valid  (pipe_v_reg[RD_LATENCY-1]),
    .pix_data   (ret_data),
    .word       (fifo_din),
    .word_valid (fifo_wr_en)
  );

  assign ram_rd_addr = addr_reg;
  assign ram_rd_en1  = issue & ~rd_bank_reg;
  assign ram_rd_en2  = issue &  rd_bank_reg;
  assign buf_done    = buf_done_reg;
  assign overrun     = overrun_reg;
  assign busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_image_ram_reader.sv
// Self-checking bench: two readers (RD_LATENCY 1 and 2) share stimulus; a
// scoreboard per reader holds the packed words each bank must produce.
module tb_image_ram_reader;

  localparam int G = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic frame = 1'b0;
  logic pulse = 1'b0;
  logic af    = 1'b0;

  logic [1:0][15:0] dout1, dout2;
  logic [1:0][7:0]  addr;
  logic [1:0]       en1, en2, wr_en, done, ovr, busy;
  logic [1:0][63:0] din;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      image_ram_reader #(.RD_LATENCY(gi + 1), .GUARD_CYC(G)) u_dut (
        .clk_cmos           (clk),
        .frame              (frame),
        .image_select_pulse (pulse),
        .ram_dout1          (dout1[gi]),
        .ram_dout2          (dout2[gi]),
        .fifo_almost_full   (af),
        .ram_rd_addr        (addr[gi]),
        .ram_rd_en1         (en1[gi]),
        .ram_rd_en2         (en2[gi]),
        .fifo_din           (din[gi]),
        .fifo_wr_en         (wr_en[gi]),
        .buf_done           (done[gi]),
        .overrun            (ovr[gi]),
        .busy               (busy[gi])
      );
    end
  endgenerate

  // Bank contents as written by the (modelled) CMOS writer.
  logic [15:0] mem [2][256];

  // RAM read ports: one registered stage for latency 1, two for latency 2.
  logic [1:0][15:0] s1a, s1b, s2a, s2b;
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (en1[i]) s1a[i] <= mem[0][addr[i]];
      if (en2[i]) s2a[i] <= mem[1][addr[i]];
      s1b[i] <= s1a[i];
      s2b[i] <= s2a[i];
    end
  end
  assign dout1[0] = s1a[0];
  assign dout2[0] = s2a[0];
  assign dout1[1] = s1b[1];
  assign dout2[1] = s2b[1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state.
  logic [63:0] exp_q  [2][$];
  int          bank_q [2][$];
  bit          pend   [2][2];
  bit          exp_ovr[2];
  bit          wb;
  int          cur_bank[2];
  int          n_wr[2], n_done[2], first_wr_cyc[2], done_cyc[2];
  logic [63:0] first_din[2];

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    wb = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_q[i].delete();
      bank_q[i].delete();
      pend[i][0]      = 1'b0;
      pend[i][1]      = 1'b0;
      exp_ovr[i]      = 1'b0;
      cur_bank[i]     = 0;
      n_wr[i]         = 0;
      n_done[i]       = 0;
      first_wr_cyc[i] = -1;
      done_cyc[i]     = -1;
      first_din[i]    = '0;
    end
  endtask

  // A writer bank switch: the finished bank is queued for reading unless it
  // is still waiting to be drained, in which case it is an overrun.
  task automatic model_pulse();
    for (int i = 0; i < 2; i++) begin
      if (pend[i][wb]) begin
        exp_ovr[i] = 1'b1;
      end else begin
        pend[i][wb] = 1'b1;
        bank_q[i].push_back(int'(wb));
        for (int g = 0; g < 64; g++) begin
          exp_q[i].push_back({mem[wb][4*g+3], mem[wb][4*g+2], mem[wb][4*g+1], mem[wb][4*g]});
        end
      end
    end
    wb = ~wb;
  endtask

  task automatic send_pulse();
    model_pulse();
    pulse = 1'b1;
    tick(1);
    pulse = 1'b0;
  endtask

  task automatic fill(int b, bit rnd);
    for (int a = 0; a < 256; a++) begin
      mem[b][a] = rnd ? 16'($urandom) : 16'(a * 3);
    end
  endtask

  task automatic do_frame();
    frame = 1'b1;
    model_clear();
    tick(2);
    frame = 1'b0;
    tick(1);
  endtask

  task automatic check_idle_outputs(string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_addr[%0d]", tag, i), 64'(addr[i]), 64'd0);
      chk($sformatf("%s_din[%0d]", tag, i), din[i], 64'd0);
      chk($sformatf("%s_ctl[%0d]", tag, i),
          64'({en1[i], en2[i], wr_en[i], done[i], ovr[i], busy[i]}), 64'd0);
    end
  endtask

  task automatic wait_idle(string tag, int budget);
    int k = 0;
    while (k < budget && !(busy == 2'b00 && exp_q[0].size() == 0 && exp_q[1].size() == 0
                           && bank_q[0].size() == 0 && bank_q[1].size() == 0)) begin
      tick(1);
      k++;
    end
    tick(3);
    chk({tag, "_drain_timeout"}, 64'(k >= budget), 64'd0);
  endtask

  task automatic check_counts(string tag, int wr, int dn);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_wr_count[%0d]", tag, i), 64'(n_wr[i]), 64'(wr));
      chk($sformatf("%s_done_count[%0d]", tag, i), 64'(n_done[i]), 64'(dn));
    end
  endtask

  // Monitor: pops the scoreboard on every FIFO write and bank start.
  task automatic monitor();
    logic [63:0] e;
    int          b;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (af) begin
          chk($sformatf("read_under_af[%0d]", i), 64'(en1[i] | en2[i]), 64'd0);
        end
        if ((en1[i] | en2[i]) && addr[i] == 8'd0) begin
          if (bank_q[i].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL bank_start[%0d]: got bank %0d expected no read", i, en2[i]);
          end else begin
            b = bank_q[i].pop_front();
            chk($sformatf("bank_order[%0d]", i), 64'(en2[i]), 64'(b));
          end
          cur_bank[i] = en2[i] ? 1 : 0;
        end
        if (wr_en[i]) begin
          n_wr[i]++;
          if (first_wr_cyc[i] < 0) begin
            first_wr_cyc[i] = cyc;
            first_din[i]    = din[i];
          end
          if (exp_q[i].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL fifo_write[%0d]: got %0h expected no write", i, din[i]);
          end else begin
            e = exp_q[i].pop_front();
            chk($sformatf("fifo_din[%0d]", i), din[i], e);
          end
        end
        if (done[i]) begin
          n_done[i]++;
          done_cyc[i] = cyc;
          pend[i][cur_bank[i]] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int p;
    int k;
    model_clear();
    fork
      monitor();
    join_none

    // Reset state.
    #1 frame = 1'b1;
    tick(2);
    check_idle_outputs("reset");
    frame = 1'b0;
    tick(2);

    // Single bank, value = address*3; also the latency comparison.
    fill(0, 1'b0);
    fill(1, 1'b1);
    p = cyc;
    send_pulse();
    wait_idle("single", 600);
    check_counts("single", 64, 1);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("single_first_din[%0d]", i), first_din[i], 64'h0009_0006_0003_0000);
      chk($sformatf("single_first_wr_cycle[%0d]", i), 64'(first_wr_cyc[i]), 64'(p + G + (i + 1) + 6));
      chk($sformatf("single_done_cycle[%0d]", i), 64'(done_cyc[i]), 64'(p + G + (i + 1) + 259));
      chk($sformatf("single_overrun[%0d]", i), 64'(ovr[i]), 64'(exp_ovr[i]));
    end

    // Alternating banks 0, 1, 0 with random contents.
    do_frame();
    fill(0, 1'b1);
    send_pulse();
    tick(300);
    fill(1, 1'b1);
    send_pulse();
    tick(300);
    fill(0, 1'b1);
    send_pulse();
    wait_idle("alt", 800);
    check_counts("alt", 192, 3);

    // Backpressure in the middle of a bank.
    do_frame();
    fill(0, 1'b1);
    send_pulse();
    tick(130);
    af = 1'b1;
    tick(20);
    af = 1'b0;
    wait_idle("bp", 800);
    check_counts("bp", 64, 1);

    // Overrun: bank 0 refilled while still being read.
    do_frame();
    fill(0, 1'b1);
    fill(1, 1'b1);
    send_pulse();
    tick(10);
    send_pulse();
    tick(2);
    for (int i = 0; i < 2; i++) chk($sformatf("ovr_before[%0d]", i), 64'(ovr[i]), 64'(exp_ovr[i]));
    tick(100);
    send_pulse();
    tick(2);
    for (int i = 0; i < 2; i++) chk($sformatf("ovr_set[%0d]", i), 64'(ovr[i]), 64'(exp_ovr[i]));
    wait_idle("ovr", 1200);
    check_counts("ovr", 128, 2);
    for (int i = 0; i < 2; i++) chk($sformatf("ovr_sticky[%0d]", i), 64'(ovr[i]), 64'(exp_ovr[i]));
    do_frame();
    for (int i = 0; i < 2; i++) chk($sformatf("ovr_cleared[%0d]", i), 64'(ovr[i]), 64'(exp_ovr[i]));

    // Abort at read address 100, then a clean bank with lane 0 aligned.
    fill(0, 1'b1);
    send_pulse();
    k = 0;
    while (!(addr[0] == 8'd100 && en1[0]) && k < 1000) begin
      tick(1);
      k++;
    end
    chk("abort_reach_addr100", 64'(k >= 1000), 64'd0);
    #2 frame = 1'b1;
    model_clear();
    #1;
    check_idle_outputs("abort");
    tick(2);
    frame = 1'b0;
    tick(1);
    fill(0, 1'b1);
    send_pulse();
    wait_idle("after_abort", 600);
    check_counts("after_abort", 64, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/image_ram_reader.md
# image_ram_reader

Drains the two 256 x 16 ping-pong pixel RAMs that the CMOS write side fills. Each full bank is read in address order, and every four 16-bit words are packed into one 64-bit word for the DDR3 write FIFO. The block sits between the ping-pong RAM read ports and the DDR3 FIFO write port in the `clk_cmos` domain. It tracks bank ownership from the writer's `image_select_pulse`.

## Interface
Parameters:
- `RD_LATENCY`, default 1: RAM read latency in cycles, from address/enable to valid `ram_dout`. Legal values are 1 and 2.
- `GUARD_CYC`, default 4: idle cycles between seeing a bank ready and issuing its first read. This covers the writer's final registered write.

Ports:
- `clk_cmos`  in  1  the single clock.
- `frame`  in  1  reset, asynchronous and active-high. It is also the frame start; it clears all state.
- `image_select_pulse`  in  1  one-cycle pulse from the writer. It marks that the writer has switched banks, so the previous bank is full.
- `ram_dout1`  in  16  read data from bank 0.
- `ram_dout2`  in  16  read data from bank 1.
- `fifo_almost_full`  in  1  DDR3 FIFO backpressure. It must assert with at least `RD_LATENCY`+2 free entries.
- `ram_rd_addr`  out  8  read address, shared by both banks.
- `ram_rd_en1`  out  1  read enable for bank 0.
- `ram_rd_en2`  out  1  read enable for bank 1.
- `fifo_din`  out  64  packed word. The first word of each group is in [15:0] and the fourth is in [63:48].
- `fifo_wr_en`  out  1  one-cycle write strobe into the FIFO.
- `buf_done`  out  1  one-cycle pulse when a bank has been fully delivered.
- `overrun`  out  1  sticky flag. It is set when the writer re-fills a bank before that bank was drained, and cleared only by `frame`.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- Reset values: all outputs are 0; the state is IDLE; `wr_bank`, `rd_bank` and `rdy[1:0]` are all 0.
- On `image_select_pulse`:
  - set `rdy[wr_bank]`, then toggle `wr_bank`.
  - if `rdy[wr_bank]` is already 1, set `overrun`. The bank is still read.
- States:
  - IDLE: if `rdy[rd_bank]`, go to GUARD and load the guard counter.
  - GUARD: count `GUARD_CYC` cycles, then go to READ with the address at 0.
  - READ: in each cycle with `!fifo_almost_full`, assert the enable for `rd_bank`, drive the address, then increment it. After issuing address 255, go to DRAIN.
  - DRAIN: wait `RD_LATENCY`+1 cycles. Then pulse `buf_done`, clear `rdy[rd_bank]`, toggle `rd_bank`, and return to IDLE.
- Packer:
  - a delay line of valid and bank-select bits, `RD_LATENCY` deep, tracks the issued reads.
  - returning data is taken from the matching `ram_dout`.
  - a 2-bit lane counter places each word into its 16-bit lane.
  - when lane 3 fills, assert `fifo_wr_en` with the full 64-bit word.
  - each bank produces exactly 64 FIFO writes.
- Simultaneous pulse and DRAIN completion on the same bank: the set wins, so `rdy` stays 1 and `overrun` is set.
- `frame` at any point aborts a read in progress and discards any partial packer word.
- The read-side address is never wider than 8 bits. It wraps from 255 only via the transition to DRAIN.

## Timing
- An address issued in cycle t returns data at t+`RD_LATENCY`. The fourth word of a group produces `fifo_wr_en` at t+`RD_LATENCY`+1.
- With no backpressure, one bank takes `GUARD_CYC` + 256 + `RD_LATENCY` + 2 cycles from the IDLE-detected ready to `buf_done`.
- `fifo_almost_full` is sampled at the same clock edge as the read issue. Reads already in flight still complete and write into the FIFO margin.
- `buf_done` is asserted in the same cycle that `rdy` is cleared.

## Structure
- Shared package contents:
  - state encoding (IDLE, GUARD, READ, DRAIN).
  - `WORDS_PER_BANK` = 256.
  - `PACK_WORDS` = 4.
  - `FIFO_W` = 64.
- One natural sub-module, `image_word_packer`. It takes valid and 16-bit data and produces the 64-bit word plus its write strobe, with a synchronous clear driven by `frame`.

## Test plan
- Single bank:
  - stimulus: after `frame`, fill bank 0 with the value (address·3) and send one pulse.
  - response: 64 `fifo_wr_en` strobes; the first `fifo_din` = {9, 6, 3, 0} in 16-bit lanes; `buf_done` once; `overrun` = 0.
- Alternating banks:
  - stimulus: send three pulses spaced 300 cycles apart.
  - response: banks are read in the order 0, 1, 0; 192 FIFO writes; 3 `buf_done` pulses.
- Backpressure:
  - stimulus: hold `fifo_almost_full` high for 20 cycles in the middle of a bank.
  - response: no read is issued while it is high; no data is lost or duplicated; the total is still 64 writes with correct ordering.
- Overrun:
  - stimulus: send two pulses 10 cycles apart, then a third before bank 0 finishes draining.
  - response: `overrun` goes to 1 and stays there until `frame`.
- Reset mid-read:
  - stimulus: assert `frame` at read address 100.
  - response: all outputs return to 0 asynchronously. A subsequent pulse reads bank 0 from address 0 with lane 0 aligned.
- Latency sweep:
  - stimulus: repeat the single-bank scenario with `RD_LATENCY` = 2.
  - response: identical FIFO contents, with every FIFO write one cycle later.
